// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative RV32M-style multiply/divide.
// One operation in flight; every result is registered and handed off with a valid/ready handshake.
module alu_mdu #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_fun,
    input  logic [XLEN-1:0] in_op1,
    input  logic [XLEN-1:0] in_op2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [XLEN-1:0]    acc_hi, acc_lo, mag_b;
    logic [2:0]         op;
    logic               neg;

    logic               accept, is_mdu, div_zero, div_ovf, iterative;
    logic               op1_neg, op2_neg, load_neg, simple_err;
    logic [XLEN-1:0]    op1_mag, op2_mag, load_a, load_b, simple_res;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && !kill;
    assign op1_neg   = in_op1[XLEN-1];
    assign op2_neg   = in_op2[XLEN-1];
    assign op1_mag   = op1_neg ? -in_op1 : in_op1;
    assign op2_mag   = op2_neg ? -in_op2 : in_op2;
    assign shamt     = in_op2[SHAMT_W-1:0];
    assign is_mdu    = (in_fun[4:3] == 2'b10);
    assign div_zero  = (in_op2 == '0);
    assign div_ovf   = !in_fun[0] && (in_op1 == MIN_NEG) && (in_op2 == '1);
    // Divide-by-zero and signed overflow skip the iteration entirely.
    assign iterative = is_mdu && !(in_fun[2] && (div_zero || div_ovf));

    always_comb begin
        load_a   = in_op1;
        load_b   = in_op2;
        load_neg = 1'b0;
        case (in_fun[2:0])
            3'b001, 3'b100: begin
                load_a   = op1_mag;
                load_b   = op2_mag;
                load_neg = op1_neg ^ op2_neg;
            end
            3'b010: begin
                load_a   = op1_mag;
                load_neg = op1_neg;
            end
            3'b110: begin
                load_a   = op1_mag;
                load_b   = op2_mag;
                load_neg = op1_neg;
            end
            default: ;
        endcase
    end

    always_comb begin
        simple_res = '0;
        simple_err = 1'b0;
        case (in_fun)
            5'd0:  simple_res = in_op1 + in_op2;
            5'd1:  simple_res = in_op1 - in_op2;
            5'd2:  simple_res = in_op1 & in_op2;
            5'd3:  simple_res = in_op1 | in_op2;
            5'd4:  simple_res = in_op1 ^ in_op2;
            5'd5:  simple_res = {{(XLEN-1){1'b0}}, $signed(in_op1) < $signed(in_op2)};
            5'd6:  simple_res = {{(XLEN-1){1'b0}}, in_op1 < in_op2};
            5'd7:  simple_res = in_op1 << shamt;
            5'd8:  simple_res = in_op1 >> shamt;
            5'd9:  simple_res = $signed(in_op1) >>> shamt;
            5'd16, 5'd17, 5'd18, 5'd19: simple_res = '0;
            5'd20, 5'd21: simple_res = div_zero ? '1 : in_op1;
            5'd22, 5'd23: simple_res = div_zero ? in_op1 : '0;
            default: simple_err = 1'b1;
        endcase
    end

    // One iteration: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]      mul_sum, div_shift;
    logic [XLEN-1:0]    div_sub, step_hi, step_lo, fin;
    logic               div_ge;
    logic [2*XLEN-1:0]  prod, prod_s;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_sub   = div_shift[XLEN-1:0] - mag_b;
        if (op[2]) begin
            step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    assign prod   = {step_hi, step_lo};
    assign prod_s = neg ? -prod : prod;

    always_comb begin
        if (!op[2])
            fin = (op[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else if (!op[1])
            fin = neg ? -step_lo : step_lo;
        else
            fin = neg ? -step_hi : step_hi;
    end

    // kill outranks both a new acceptance and completion of the iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mag_b     <= '0;
            op        <= '0;
            neg       <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (iterative) begin
                            state  <= BUSY;
                            cnt    <= '0;
                            acc_hi <= '0;
                            acc_lo <= load_a;
                            mag_b  <= load_b;
                            op     <= in_fun[2:0];
                            neg    <= load_neg;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= simple_res;
                            out_err   <= simple_err;
                        end
                    end
                end
                BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(XLEN-1)) begin
                        state     <= IDLE;
                        out_valid <= 1'b1;
                        out_data  <= fin;
                        out_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked execute unit for the ncore integer pipeline.
- Extends the combinational ALU operation set with:
  - correct signed SLT and arithmetic SRA;
  - RV32M-style multiply and divide, computed iteratively.
- Sits in the execute stage behind the decode/issue register and in front of writeback.
- All results are registered; one operation is in flight at a time.

Parameters:
- XLEN, 32: operand and result width; must be a power of two and at least 8.
- SHAMT_W, $clog2(XLEN): number of op2 LSBs used as the shift amount.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: request present.
- in_ready, output, 1: unit can accept a request this cycle.
- in_fun, input, 5: operation code (table under Behaviour).
- in_op1, input, XLEN: operand 1 (rs1).
- in_op2, input, XLEN: operand 2 (rs2 or immediate).
- kill, input, 1: flush the in-flight operation and any unaccepted result.
- out_valid, output, 1: result present.
- out_ready, input, 1: consumer takes the result.
- out_data, output, XLEN: result.
- out_err, output, 1: in_fun was an undefined code; out_data is 0 in that case.

Behaviour:
- Operation codes (decimal):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed compare), 6 SLTU (unsigned compare).
  - 7 SLL, 8 SRL (logical), 9 SRA (sign-filling).
  - 16 MUL (low XLEN bits), 17 MULH (signed×signed, high half), 18 MULHSU (signed op1 × unsigned op2, high half), 19 MULHU (unsigned, high half).
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - All other codes are undefined.
- Handshake:
  - A request is accepted on an edge where in_valid && in_ready && !kill.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - out_data and out_err are held stable while out_valid && !out_ready.
- States:
  - IDLE: waiting for a request.
  - BUSY: iterative multiply/divide in progress.
  - (RESULT is represented by out_valid.)
- Single-cycle path (simple ops, undefined codes, DIV special cases):
  - Result is registered; out_valid rises the cycle after acceptance (latency 1).
  - State stays IDLE.
  - Back-to-back requests are sustained at one per cycle while out_ready=1.
- Iterative path (MUL*/DIV* in the normal case):
  - On acceptance, go IDLE→BUSY and clear the iteration counter.
  - Each BUSY cycle performs one shift-add step (multiply) or one restoring-subtract step (divide).
  - After XLEN steps, go BUSY→IDLE and set out_valid.
  - Latency is XLEN+1 cycles from the acceptance edge to the first cycle out_valid is high.
- Signed multiply/divide:
  - Operands are converted to magnitudes on acceptance.
  - The result is negated at the final step when the sign rule requires it.
  - MUL result is identical for all signedness variants.
  - REM takes the sign of the dividend.
- Division special cases (latency 1, no BUSY):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op1.
  - Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV gives op1; REM gives 0.
- Shifts:
  - Use in_op2[SHAMT_W-1:0] only; upper bits are ignored.
  - A shift by 0 returns op1 unchanged.
- ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
- kill:
  - Returns the unit to IDLE on the next edge.
  - Clears out_valid and the counter.
  - Takes priority over acceptance and over completion in the same cycle.
- Reset (synchronous):
  - state=IDLE, out_valid=0, out_data=0, out_err=0, counter=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset during BUSY abandons the operation with no output.
- Simultaneous out_valid && out_ready && in_valid in IDLE:
  - The old result retires and the new request is accepted on the same edge.

Test Plan:
- Simple ops, XLEN=32:
  - ADD 0xFFFFFFFF+1 gives 0.
  - SUB 0-1 gives 0xFFFFFFFF.
  - SLT(0xFFFFFFFF, 1) gives 1; SLTU of the same operands gives 0.
  - SRA(0x80000000, 4) gives 0xF8000000; SRL of the same gives 0x08000000.
  - SLL(1, 0x25) gives 0x20.
  - Every result appears exactly 1 cycle after acceptance.
- Back-to-back ADD stream with out_ready=1:
  - One result per cycle, in order.
  - out_ready low for 3 cycles: out_data held, in_ready=0, no request lost.
- Multiply:
  - MUL(-3, 7) gives 0xFFFFFFEB.
  - MULH(-3, 7) gives 0xFFFFFFFF.
  - MULHU(0xFFFFFFFF, 0xFFFFFFFF) gives 0xFFFFFFFE.
  - MULHSU(-1, 2) gives 0xFFFFFFFF.
  - out_valid exactly 33 cycles after acceptance; in_ready=0 throughout.
- Divide:
  - DIV(-7, 2) gives -3; REM(-7, 2) gives -1.
  - DIVU(7, 0) gives 0xFFFFFFFF; REMU(7, 0) gives 7 (latency 1).
  - DIV(0x80000000, -1) gives 0x80000000; REM of the same gives 0.
- kill:
  - Asserted at cycle 10 of a DIV: no out_valid ever produced for it.
  - in_ready=1 next cycle; a following ADD completes normally.
  - Repeat with reset instead of kill: same result.
- Undefined code 31: out_err=1 and out_data=0 after 1 cycle.
  - XLEN=64 smoke run: MUL latency is 65 cycles; SRA uses a 6-bit shift amount.
